// File: rtl/gray_pack_pkg.sv
// Shared constants and state encodings for the gray line packer.
package gray_pack_pkg;

   localparam int HDR_LEN = 4;

   typedef enum logic [1:0] {IDLE, REQ, HDR, PAY} rd_st_t;

   typedef enum logic [1:0] {EMPTY, FILL, FULL, READ} bank_st_t;

endpackage

// File: rtl/line_bank_ram.sv
// Two-bank line store: simple dual-port RAM, bank select is the address MSB.
// One-cycle registered read; o_rdata holds its value while i_re is low.
module line_bank_ram #(
   parameter int MAX_W = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW:0]   i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic          i_re,
   input  logic [AW:0]   i_raddr,
   output logic [7:0]    o_rdata
);

   logic [7:0] r_mem [0:2*MAX_W-1];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/gray_line_packer.sv
// Ping-pong line capture; each completed line leaves as a 4-byte header + payload packet.
// First byte one cycle after tx_ack, then 1 byte/clk; output holds while tx_valid & !tx_ready.
module gray_line_packer
   import gray_pack_pkg::*;
#(
   parameter logic [7:0] CAM_ID = 8'd0,
   parameter int         MAX_W  = 1024,
   parameter int         AW     = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pic_start,
   input  logic        href_start,
   input  logic        href_end,
   input  logic        gray_en,
   input  logic [7:0]  gray_data,
   output logic        tx_req,
   output logic [15:0] tx_len,
   input  logic        tx_ack,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_last,
   input  logic        tx_ready,
   output logic [15:0] drop_cnt,
   output logic        ovf
);

   localparam logic [AW:0] W_MAX = MAX_W[AW:0];
   localparam logic [1:0]  H_LST = 2'(HDR_LEN - 1);

   // bank bookkeeping
   bank_st_t    r_bst  [2];
   logic [AW:0] r_len  [2];
   logic [15:0] r_lnum [2];
   logic [7:0]  r_frm  [2];
   logic        r_oldest;

   // write side
   logic        r_wr_act;
   logic        r_wbank;
   logic [AW:0] r_wptr;
   logic [7:0]  r_frame_cnt;
   logic [15:0] r_line_cnt;
   logic [15:0] r_drop;
   logic        r_ovf;

   // read side
   rd_st_t      r_st;
   logic        r_sel;
   logic [1:0]  r_hidx;
   logic [AW:0] r_raddr;
   logic        r_pend;
   logic        r_pend_last;
   logic        r_sk_vld;
   logic [7:0]  r_sk_dat;
   logic        r_sk_last;
   logic        r_vld;
   logic [7:0]  r_dat;
   logic        r_last;

   rd_st_t      w_st_nxt;
   bank_st_t    w_bst_nxt [2];
   logic        w_claim_ok;
   logic        w_claim_bank;
   logic        w_full_ptr;
   logic        w_wr;
   logic [AW:0] w_end_len;
   logic        w_pick_vld;
   logic        w_pick;
   logic        w_adv;
   logic        w_rel;
   logic        w_more;
   logic        w_issue;
   logic        w_issue_last;
   logic [1:0]  w_hdr_idx;
   logic [7:0]  w_hdr_byte;
   logic [7:0]  w_ram_q;

   assign w_full_ptr = (r_wptr == W_MAX);
   assign w_wr       = r_wr_act && gray_en && !href_start && !w_full_ptr;
   assign w_end_len  = r_wptr + {{AW{1'b0}}, w_wr};

   assign w_pick_vld = (r_bst[0] == FULL) || (r_bst[1] == FULL);
   assign w_pick     = ((r_bst[0] == FULL) && (r_bst[1] == FULL)) ? r_oldest
                                                                  : (r_bst[1] == FULL);

   assign w_adv        = !r_vld || tx_ready;
   assign w_rel        = r_vld && tx_ready && r_last;
   assign w_more       = (r_raddr != r_len[r_sel]);
   assign w_issue_last = ((r_raddr + (AW+1)'(1)) == r_len[r_sel]);
   // Header must be fully loaded before the first payload read lands in the skid slot.
   assign w_issue = w_more &&
                    (((r_st == PAY) && (w_adv || (!r_sk_vld && !r_pend))) ||
                     ((r_st == HDR) && (r_hidx == H_LST) && w_adv));

   assign w_hdr_idx = (r_st == REQ) ? 2'd0 : r_hidx;

   always_comb begin
      w_hdr_byte = CAM_ID;
      case (w_hdr_idx)
         2'd0:    w_hdr_byte = CAM_ID;
         2'd1:    w_hdr_byte = r_frm[r_sel];
         2'd2:    w_hdr_byte = r_lnum[r_sel][15:8];
         default: w_hdr_byte = r_lnum[r_sel][7:0];
      endcase
   end

   // Release by the reader is applied before a same-cycle write claim.
   always_comb begin
      w_bst_nxt    = r_bst;
      w_claim_ok   = 1'b0;
      w_claim_bank = 1'b0;
      if (w_rel) w_bst_nxt[r_sel] = EMPTY;
      if ((r_st == IDLE) && w_pick_vld) w_bst_nxt[w_pick] = READ;
      if (href_start) begin
         if (r_wr_act) w_bst_nxt[r_wbank] = EMPTY;
         if (w_bst_nxt[0] == EMPTY) begin
            w_claim_ok   = 1'b1;
            w_claim_bank = 1'b0;
         end else if (w_bst_nxt[1] == EMPTY) begin
            w_claim_ok   = 1'b1;
            w_claim_bank = 1'b1;
         end
         if (w_claim_ok) w_bst_nxt[w_claim_bank] = FILL;
      end else if (href_end && r_wr_act) begin
         w_bst_nxt[r_wbank] = (w_end_len != '0) ? FULL : EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bst[0]    <= EMPTY;
         r_bst[1]    <= EMPTY;
         r_len[0]    <= '0;
         r_len[1]    <= '0;
         r_lnum[0]   <= '0;
         r_lnum[1]   <= '0;
         r_frm[0]    <= '0;
         r_frm[1]    <= '0;
         r_oldest    <= 1'b0;
         r_wr_act    <= 1'b0;
         r_wbank     <= 1'b0;
         r_wptr      <= '0;
         r_frame_cnt <= '0;
         r_line_cnt  <= '0;
         r_drop      <= '0;
         r_ovf       <= 1'b0;
      end else begin
         r_bst <= w_bst_nxt;
         if (pic_start) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
            r_line_cnt  <= '0;
         end else if (href_end) begin
            r_line_cnt <= r_line_cnt + 16'd1;
         end
         if (href_start) begin
            r_wptr   <= '0;
            r_wr_act <= w_claim_ok;
            if (w_claim_ok) r_wbank <= w_claim_bank;
            if (!w_claim_ok && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
         end else begin
            if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
            if (r_wr_act && gray_en && w_full_ptr) r_ovf <= 1'b1;
            if (href_end && r_wr_act) begin
               r_wr_act <= 1'b0;
               if (w_end_len != '0) begin
                  r_len[r_wbank]  <= w_end_len;
                  r_lnum[r_wbank] <= r_line_cnt;
                  r_frm[r_wbank]  <= r_frame_cnt;
                  // a bank already waiting as FULL was filled earlier and stays oldest
                  if (r_bst[~r_wbank] != FULL) r_oldest <= r_wbank;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_st <= IDLE;
      else        r_st <= w_st_nxt;
   end

   always_comb begin
      w_st_nxt = r_st;
      tx_req   = 1'b0;
      tx_len   = '0;
      case (r_st)
         IDLE: if (w_pick_vld) w_st_nxt = REQ;
         REQ: begin
            tx_req = 1'b1;
            tx_len = 16'(r_len[r_sel]) + 16'(HDR_LEN);
            if (tx_ack) w_st_nxt = HDR;
         end
         HDR: if (w_adv && (r_hidx == H_LST)) w_st_nxt = PAY;
         PAY: if (w_rel) w_st_nxt = IDLE;
         default: w_st_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sel       <= 1'b0;
         r_hidx      <= '0;
         r_raddr     <= '0;
         r_pend      <= 1'b0;
         r_pend_last <= 1'b0;
         r_sk_vld    <= 1'b0;
         r_sk_dat    <= '0;
         r_sk_last   <= 1'b0;
         r_vld       <= 1'b0;
         r_dat       <= '0;
         r_last      <= 1'b0;
      end else begin
         if ((r_st == IDLE) && w_pick_vld) r_sel <= w_pick;

         if ((r_st == REQ) && tx_ack) begin
            r_hidx  <= 2'd1;
            r_raddr <= '0;
         end else begin
            if ((r_st == HDR) && w_adv) r_hidx <= r_hidx + 2'd1;
            if (w_issue) r_raddr <= r_raddr + (AW+1)'(1);
         end

         r_pend <= w_issue;
         if (w_issue) r_pend_last <= w_issue_last;

         // Source priority keeps order: skid, then in-flight RAM byte, then header.
         if (w_adv) begin
            if (r_sk_vld) begin
               r_vld    <= 1'b1;
               r_dat    <= r_sk_dat;
               r_last   <= r_sk_last;
               r_sk_vld <= 1'b0;
            end else if (r_pend) begin
               r_vld  <= 1'b1;
               r_dat  <= w_ram_q;
               r_last <= r_pend_last;
            end else if (((r_st == REQ) && tx_ack) || (r_st == HDR)) begin
               r_vld  <= 1'b1;
               r_dat  <= w_hdr_byte;
               r_last <= 1'b0;
            end else begin
               r_vld  <= 1'b0;
               r_last <= 1'b0;
            end
         end else if (r_pend) begin
            r_sk_vld  <= 1'b1;
            r_sk_dat  <= w_ram_q;
            r_sk_last <= r_pend_last;
         end
      end
   end

   line_bank_ram #(
      .MAX_W (MAX_W),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_wr),
      .i_waddr ({r_wbank, r_wptr[AW-1:0]}),
      .i_wdata (gray_data),
      .i_re    (w_issue),
      .i_raddr ({r_sel, r_raddr[AW-1:0]}),
      .o_rdata (w_ram_q)
   );

   assign tx_valid = r_vld;
   assign tx_data  = r_dat;
   assign tx_last  = r_last;
   assign drop_cnt = r_drop;
   assign ovf      = r_ovf;

endmodule

// File: tb/tb_gray_line_packer.sv
// Directed bench for gray_line_packer: table of line/packet vectors plus hand sequences
// for bank exhaustion, empty lines, reset mid-payload and frame counter wrap.
module tb_gray_line_packer;

   localparam logic [7:0] CAM = 8'h5A;

   logic        clk;
   logic        rst_n;
   logic        pic_start;
   logic        href_start;
   logic        href_end;
   logic        gray_en;
   logic [7:0]  gray_data;
   logic        tx_req;
   logic [15:0] tx_len;
   logic        tx_ack;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_last;
   logic        tx_ready;
   logic [15:0] drop_cnt;
   logic        ovf;

   int n_chk  = 0;
   int n_pass = 0;

   gray_line_packer #(.CAM_ID(CAM), .MAX_W(1024), .AW(10)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pic_start  (pic_start),
      .href_start (href_start),
      .href_end   (href_end),
      .gray_en    (gray_en),
      .gray_data  (gray_data),
      .tx_req     (tx_req),
      .tx_len     (tx_len),
      .tx_ack     (tx_ack),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_last    (tx_last),
      .tx_ready   (tx_ready),
      .drop_cnt   (drop_cnt),
      .ovf        (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // All tasks are entered at a negedge and return at a negedge.
   task automatic pulse_pic();
      pic_start = 1'b1;
      @(negedge clk);
      pic_start = 1'b0;
   endtask

   task automatic send_line(input int n, input int seed, input bit same_end);
      href_start = 1'b1;
      @(negedge clk);
      href_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         gray_en   = 1'b1;
         gray_data = 8'((i + seed) % 256);
         if (same_end && (i == n - 1)) href_end = 1'b1;
         @(negedge clk);
      end
      gray_en = 1'b0;
      if (!(same_end && (n > 0))) begin
         href_end = 1'b1;
         @(negedge clk);
      end
      href_end = 1'b0;
   endtask

   task automatic wait_req(input string tag, output bit ok);
      int wt = 0;
      while (!tx_req && (wt < 3000)) begin
         @(negedge clk);
         wt++;
      end
      ok = tx_req;
      if (!ok) chk({tag, "_req_timeout"}, 0, 1);
   endtask

   task automatic recv(input int npay, input int seed, input int frm, input int lnum,
                       input int ackdly, input bit rmode, input string tag);
      logic [7:0] expq[$];
      int   idx = 0, bad = 0, lasterr = 0, stab = 0, cyc = 0, total;
      bit   stall = 1'b0, rdy, ok;
      logic [7:0] hd = '0;
      logic hl = 1'b0;
      wait_req(tag, ok);
      if (!ok) return;
      chk({tag, "_tx_len"}, int'(tx_len), npay + 4);
      repeat (ackdly) @(negedge clk);
      chk({tag, "_req_hold"}, int'(tx_req), 1);
      tx_ack = 1'b1;
      @(negedge clk);
      tx_ack = 1'b0;
      chk({tag, "_first_vld"}, int'(tx_valid), 1);
      chk({tag, "_req_clr"}, int'(tx_req), 0);
      expq.push_back(CAM);
      expq.push_back(8'(frm));
      expq.push_back(8'(lnum >> 8));
      expq.push_back(8'(lnum));
      for (int i = 0; i < npay; i++) expq.push_back(8'((i + seed) % 256));
      total = npay + 4;
      while ((idx < total) && (cyc < 20000)) begin
         if (stall && (!tx_valid || (tx_data != hd) || (tx_last != hl))) stab++;
         rdy = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
         tx_ready = rdy;
         if (tx_valid && rdy) begin
            if (tx_data != expq[idx]) bad++;
            if (tx_last != (idx == total - 1)) lasterr++;
            idx++;
         end
         stall = tx_valid && !rdy;
         hd    = tx_data;
         hl    = tx_last;
         @(negedge clk);
         cyc++;
      end
      tx_ready = 1'b1;
      chk({tag, "_byte_count"}, idx, total);
      chk({tag, "_byte_errors"}, bad, 0);
      chk({tag, "_last_errors"}, lasterr, 0);
      chk({tag, "_stall_unstable"}, stab, 0);
      if (!rmode) chk({tag, "_cycles"}, cyc, total);
   endtask

   task automatic no_req_for(input int n, input string tag);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         if (tx_req || tx_valid) seen++;
         @(negedge clk);
      end
      chk(tag, seen, 0);
   endtask

   typedef struct {
      bit pic;
      int n;
      int seed;
      bit same_end;
      int ackdly;
      bit rmode;
      int exp_pay;
      int exp_frm;
      int exp_lnum;
      int exp_ovf;
      int exp_drop;
   } vec_t;

   vec_t tv [6];

   initial begin
      bit ok;
      int cnt, b;
      tv[0] = '{1'b1,  640,   0, 1'b0, 5, 1'b0,  640, 1, 0, 0, 0};
      tv[1] = '{1'b0,  640,   0, 1'b0, 2, 1'b1,  640, 1, 1, 0, 0};
      tv[2] = '{1'b0, 1100,   7, 1'b0, 0, 1'b0, 1024, 1, 2, 1, 0};
      tv[3] = '{1'b0,  200,   3, 1'b0, 1, 1'b1,  200, 1, 3, 1, 0};
      tv[4] = '{1'b1,    1,   9, 1'b1, 0, 1'b0,    1, 2, 0, 1, 0};
      tv[5] = '{1'b0,   33, 100, 1'b1, 3, 1'b1,   33, 2, 1, 1, 0};

      rst_n = 1'b0; pic_start = 1'b0; href_start = 1'b0; href_end = 1'b0;
      gray_en = 1'b0; gray_data = '0; tx_ack = 1'b0; tx_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_tx_req", int'(tx_req), 0);
      chk("rst_tx_len", int'(tx_len), 0);
      chk("rst_tx_valid", int'(tx_valid), 0);
      chk("rst_tx_last", int'(tx_last), 0);
      chk("rst_tx_data", int'(tx_data), 0);
      chk("rst_drop_cnt", int'(drop_cnt), 0);
      chk("rst_ovf", int'(ovf), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         string tag;
         tag = $sformatf("vec%0d", v);
         if (tv[v].pic) pulse_pic();
         send_line(tv[v].n, tv[v].seed, tv[v].same_end);
         recv(tv[v].exp_pay, tv[v].seed, tv[v].exp_frm, tv[v].exp_lnum,
              tv[v].ackdly, tv[v].rmode, tag);
         chk({tag, "_ovf"}, int'(ovf), tv[v].exp_ovf);
         chk({tag, "_drop"}, int'(drop_cnt), tv[v].exp_drop);
      end

      // empty line takes line index 2 but never becomes a packet
      send_line(0, 0, 1'b0);
      no_req_for(20, "empty_line_no_pkt");

      // bank exhaustion: two lines buffered, third dropped
      send_line(10, 40, 1'b0);
      send_line(10, 50, 1'b0);
      send_line(10, 60, 1'b0);
      chk("exhaust_drop", int'(drop_cnt), 1);
      recv(10, 40, 2, 3, 2, 1'b0, "exhaust_a");
      recv(10, 50, 2, 4, 0, 1'b1, "exhaust_b");
      no_req_for(30, "exhaust_no_third");

      // reset while payload byte 100 is on the bus
      send_line(300, 5, 1'b0);
      wait_req("rst_pay", ok);
      if (ok) begin
         tx_ack = 1'b1;
         @(negedge clk);
         tx_ack = 1'b0;
         cnt = 0;
         b = 0;
         while ((cnt < 104) && (b < 1000)) begin
            if (tx_valid) cnt++;
            @(negedge clk);
            b++;
         end
         chk("rst_pay_reached", cnt, 104);
         chk("rst_pay_byte100", int'(tx_data), 105);
      end
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_pay_tx_valid", int'(tx_valid), 0);
      chk("rst_pay_tx_req", int'(tx_req), 0);
      chk("rst_pay_ovf", int'(ovf), 0);
      chk("rst_pay_drop", int'(drop_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      no_req_for(20, "rst_pay_discarded");

      // frame counter runs 1..255 then wraps to 0
      for (int k = 1; k <= 256; k++) begin
         pulse_pic();
         send_line(4, k, 1'b0);
         recv(4, k, k % 256, 0, 0, 1'b0, $sformatf("wrap%0d", k));
      end
      chk("wrap_drop", int'(drop_cnt), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
